data_cache_arbiter: RTL and testbench
=====================================

# data_cache_arbiter

Two-port arbiter and sequencer placed in front of the single-ported synchronous data cache. Accepts read/write requests from two requesters (port 0: pipeline MEM stage, port 1: loader/debug port), grants one at a time, drives the cache strobes for exactly one cycle, and returns the cache output to the owning requester with a one-cycle valid pulse. Selection between simultaneous requests is fixed-priority or round-robin, chosen at compile time.

## Interface

- DATA_W, 32, data width
- ADDR_W, 8, word address width (256-entry cache)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- p0_req / p1_req  in  1  request; held with payload until grant seen
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_addr / p1_addr  in  ADDR_W  word address
- p0_wdata / p1_wdata  in  DATA_W  write data
- p0_gnt / p1_gnt  out  1  registered one-cycle grant pulse
- p0_rvalid / p1_rvalid  out  1  registered one-cycle completion pulse
- p0_rdata / p1_rdata  out  DATA_W  registered response data, held until next completion on that port
- mem_data  out  DATA_W  to cache data input
- mem_addr  out  ADDR_W  to cache address
- mem_read  out  1  to cache DataRead
- mem_write  out  1  to cache DataWrite
- mem_q  in  DATA_W  from cache data_out
- busy  out  1  high when state is not IDLE

## Operation

- States: IDLE, ISSUE, RESP.
- Arbitration happens at each posedge where state is IDLE or RESP and at least one req is high: winner latched (owner, we, addr, wdata), owner's gnt pulses, state -> ISSUE. No request: IDLE -> IDLE, RESP -> IDLE.
- ISSUE: mem_addr/mem_data from latched command; mem_read = ~we, mem_write = we; never both high. Next edge -> RESP; cache performs the access on that edge.
- RESP: mem_q valid. At the closing edge mem_q -> owner's rdata, owner's rvalid pulses next cycle. Writes also complete with rvalid; rdata then equals the written data (cache passes data through).
- mem_read/mem_write low in IDLE and RESP; mem_addr/mem_data hold last values.
- Requester protocol: hold req and payload stable until gnt observed; drop req the cycle after gnt unless issuing a new access. req still high at the RESP edge is a new request.
- Non-winning requester keeps req high; never dropped.

## Timing

- Reset (async assert): state IDLE; all gnt, rvalid, mem_read, mem_write, busy = 0; rdata, mem_addr, mem_data = 0; round-robin pointer favours port 0. In-flight access abandoned, no rvalid issued; strobes fall immediately so the cache edge does not see them.
- Request sampled at edge E: gnt and strobes high in cycle E+1, mem_q valid E+2, rvalid and rdata in E+3.
- Back-to-back: sustained throughput one access per 2 cycles (RESP -> ISSUE); rvalid of access n coincides with gnt of access n+1.
- Read latency req-sampled to rvalid: 3 cycles.
- Simultaneous requests: resolved per Configuration; loser granted at the next arbitration edge.

## Configuration

- ARB_ROUND_ROBIN_EN defined: round-robin; pointer moves to the other port after each grant; on conflict the port not most recently granted wins. Reset pointer favours port 0.
- Undefined: fixed priority, port 0 always wins conflicts; port 1 can starve under continuous port 0 traffic.

## Test plan

- Reset mid-ISSUE (p0 write addr 0x10 data 0xDEADBEEF) -> strobes drop at once, no rvalid, later read 0x10 returns prior contents.
- p1 write 0x05 = 0x12345678, then p0 read 0x05 -> p0_rvalid 3 cycles after request sample, p0_rdata = 0x12345678; p1_rvalid with p1_rdata = 0x12345678.
- p0 and p1 both read continuously (addrs 0x01, 0x02) with ARB_ROUND_ROBIN_EN -> grants alternate p0, p1, p0, ...; one grant every 2 cycles.
- Same stimulus without macro -> only p0 granted while p0_req held; p1 granted the first arbitration edge after p0_req drops.
- Single p0 read 0xFF -> mem_read high exactly one cycle, mem_write never high, busy high 2 cycles, state returns IDLE.
- p0 write 0x00 = 0xA5A5A5A5 then immediate p0 read 0x00 (req held) -> write rvalid and read gnt same cycle; read returns 0xA5A5A5A5.

Source files
------------

// File: rtl/data_cache_arbiter.sv
// data_cache_arbiter: grants one of two requesters at a time onto a single-ported synchronous cache
// and routes the cache output back to the owner. Define ARB_ROUND_ROBIN_EN for round-robin, else port 0 priority.
module data_cache_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p0_gnt,
   output logic              p1_gnt,
   output logic              p0_rvalid,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [DATA_W-1:0] mem_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_q,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   // Handshake: req acts as valid and is held with its payload until the one-cycle gnt (the accept);
   // rvalid marks completion on the owning port and has no back-pressure.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic                w_arb;
   logic                w_winner;
   logic                w_resp;
   logic                w_sel_we;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;

   logic                r_owner;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_p0_gnt;
   logic                r_p1_gnt;
   logic                r_p0_rvalid;
   logic                r_p1_rvalid;
   logic [DATA_W-1:0]   r_p0_rdata;
   logic [DATA_W-1:0]   r_p1_rdata;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_rr_ptr;  // port favoured on the next conflict

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rr_ptr <= 1'b0;
      end else if (w_arb) begin
         r_rr_ptr <= ~w_winner;
      end
   end

   always_comb begin
      w_winner = 1'b0;
      if (p0_req && p1_req) begin
         w_winner = r_rr_ptr;
      end else begin
         w_winner = p1_req;
      end
   end
`else
   always_comb begin
      w_winner = 1'b0;
      if (!p0_req) begin
         w_winner = p1_req;
      end
   end
`endif

   assign w_sel_we    = w_winner ? p1_we    : p0_we;
   assign w_sel_addr  = w_winner ? p1_addr  : p0_addr;
   assign w_sel_wdata = w_winner ? p1_wdata : p0_wdata;
   assign w_resp      = (r_state == RESP);

   always_comb begin
      w_next_state = r_state;
      w_arb        = 1'b0;
      case (r_state)
         IDLE, RESP: begin
            if (p0_req || p1_req) begin
               w_arb        = 1'b1;
               w_next_state = ISSUE;
            end else begin
               w_next_state = IDLE;
            end
         end
         ISSUE:   w_next_state = RESP;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_owner     <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_p0_gnt    <= 1'b0;
         r_p1_gnt    <= 1'b0;
         r_p0_rvalid <= 1'b0;
         r_p1_rvalid <= 1'b0;
         r_p0_rdata  <= '0;
         r_p1_rdata  <= '0;
      end else begin
         r_state     <= w_next_state;
         r_p0_gnt    <= w_arb & ~w_winner;
         r_p1_gnt    <= w_arb & w_winner;
         r_p0_rvalid <= w_resp & ~r_owner;
         r_p1_rvalid <= w_resp & r_owner;
         if (w_arb) begin
            r_owner <= w_winner;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
         end
         // Capture uses the owner of the completing access, before a new winner overwrites it.
         if (w_resp && !r_owner) begin
            r_p0_rdata <= mem_q;
         end
         if (w_resp && r_owner) begin
            r_p1_rdata <= mem_q;
         end
      end
   end

   // Strobes decode straight from state so an asynchronous reset removes them before the cache edge.
   assign mem_read  = (r_state == ISSUE) & ~r_we;
   assign mem_write = (r_state == ISSUE) & r_we;
   assign mem_addr  = r_addr;
   assign mem_data  = r_wdata;
   assign p0_gnt    = r_p0_gnt;
   assign p1_gnt    = r_p1_gnt;
   assign p0_rvalid = r_p0_rvalid;
   assign p1_rvalid = r_p1_rvalid;
   assign p0_rdata  = r_p0_rdata;
   assign p1_rdata  = r_p1_rdata;
   assign busy      = (r_state != IDLE);
   assign dbg_state = r_state;

endmodule

// File: tb/tb_data_cache_arbiter.sv
// tb_data_cache_arbiter: drives both requesters against a behavioural cache and checks every cycle
// against a transaction-level model of grants, completions and cache contents.
module tb_data_cache_arbiter;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
   logic [ADDR_W-1:0] p0_addr = '0, p1_addr = '0;
   logic [DATA_W-1:0] p0_wdata = '0, p1_wdata = '0;
   logic              p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
   logic [DATA_W-1:0] p0_rdata, p1_rdata, mem_data, mem_q;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_read, mem_write, busy;
   logic [1:0]        dbg_state;

   int tests = 0;
   int fails = 0;
   int pcnt = 0;
   int req_cnt0 = 0, req_cnt1 = 0;

   typedef struct packed {
      logic              bubble;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } cmd_t;
   cmd_t cmdq0[$];
   cmd_t cmdq1[$];

   typedef struct {
      logic              port;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      int                due;
   } acc_t;
   acc_t pend[$];

   typedef struct {
      logic              port;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] exp_rdata;
      int                exp_lat;
   } vec_t;
   vec_t vecs[8];

   logic [DATA_W-1:0] cache_mem [256];
   logic [DATA_W-1:0] mem_m [256];
   logic [DATA_W-1:0] last_rd [2];
   int                glog_port[$];
   int                glog_cyc[$];

   data_cache_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
      .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
      .mem_data(mem_data), .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
      .mem_q(mem_q), .busy(busy), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) pcnt <= pcnt + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, got no summary, required finish");
      $fatal(1, "watchdog expired");
   end

   // behavioural single-ported synchronous cache, write data passes through to q
   initial begin
      for (int i = 0; i < 256; i++) begin
         cache_mem[i] = {24'hC0DE00, 8'(i)};
         mem_m[i]     = {24'hC0DE00, 8'(i)};
      end
   end

   always @(posedge clk) begin
      if (mem_write) begin
         cache_mem[mem_addr] = mem_data;
         mem_q <= mem_data;
      end else if (mem_read) begin
         mem_q <= cache_mem[mem_addr];
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // requester drivers: hold req and payload until gnt, then load the next command
   initial begin : drv0
      cmd_t c;
      forever begin
         @(posedge clk); #1;
         if (p0_req && p0_gnt) p0_req = 1'b0;
         if (!p0_req && cmdq0.size() > 0) begin
            c = cmdq0.pop_front();
            if (!c.bubble) begin
               p0_req = 1'b1; p0_we = c.we; p0_addr = c.addr; p0_wdata = c.data; req_cnt0 = pcnt;
            end
         end
      end
   end

   initial begin : drv1
      cmd_t c;
      forever begin
         @(posedge clk); #1;
         if (p1_req && p1_gnt) p1_req = 1'b0;
         if (!p1_req && cmdq1.size() > 0) begin
            c = cmdq1.pop_front();
            if (!c.bubble) begin
               p1_req = 1'b1; p1_we = c.we; p1_addr = c.addr; p1_wdata = c.data; req_cnt1 = pcnt;
            end
         end
      end
   end

   // scoreboard: accesses are serialised, an arbitration edge is any edge not directly after a grant,
   // each grant completes two cycles later and cache effects apply in completion order
   int               cyc = 0;
   int               last_gnt_cyc = -10;
   logic             rr_last = 1'b1;
   logic             prev_rst = 1'b1;
   logic [1:0]       prev_req = 2'b00;
   logic [1:0]       prev_we = 2'b00;
   logic [ADDR_W-1:0] prev_addr [2];
   logic [DATA_W-1:0] prev_data [2];

   always @(negedge clk) begin : monitor
      logic [1:0] exp_gnt;
      logic [1:0] exp_rv;
      logic       w;
      logic       was_issue;
      acc_t       a;
      cyc++;
      if (reset || prev_rst) begin
         pend.delete();
         last_gnt_cyc = -10;
         rr_last = 1'b1;
         last_rd[0] = '0;
         last_rd[1] = '0;
         check("reset_ctrl", 64'({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_read, mem_write, busy}), 64'd0);
         check("reset_rdata", {p0_rdata, p1_rdata}, 64'd0);
         check("reset_mem", 64'({mem_addr, mem_data}), 64'd0);
      end else begin
         exp_gnt = 2'b00;
         exp_rv = 2'b00;
         was_issue = (last_gnt_cyc == cyc - 1);
         if (pend.size() > 0 && pend[0].due == cyc) begin
            a = pend.pop_front();
            exp_rv[a.port] = 1'b1;
            if (a.we) mem_m[a.addr] = a.data;
            last_rd[a.port] = mem_m[a.addr];
         end
         if (prev_req != 2'b00 && !was_issue) begin
            if (prev_req == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
               w = ~rr_last;
`else
               w = 1'b0;
`endif
            end else begin
               w = prev_req[1];
            end
            exp_gnt[w] = 1'b1;
            rr_last = w;
            last_gnt_cyc = cyc;
            pend.push_back('{w, prev_we[w], prev_addr[w], prev_data[w], cyc + 2});
            glog_port.push_back(int'(w));
            glog_cyc.push_back(cyc);
            check("mem_strobe", 64'({mem_read, mem_write}), 64'({~prev_we[w], prev_we[w]}));
            check("mem_addr", 64'(mem_addr), 64'(prev_addr[w]));
            if (prev_we[w]) check("mem_data", 64'(mem_data), 64'(prev_data[w]));
         end else begin
            check("mem_strobe_idle", 64'({mem_read, mem_write}), 64'd0);
         end
         check("gnt", 64'({p1_gnt, p0_gnt}), 64'(exp_gnt));
         check("rvalid", 64'({p1_rvalid, p0_rvalid}), 64'(exp_rv));
         check("p0_rdata", 64'(p0_rdata), 64'(last_rd[0]));
         check("p1_rdata", 64'(p1_rdata), 64'(last_rd[1]));
         check("busy", 64'(busy), 64'((exp_gnt != 2'b00) || was_issue));
      end
      prev_rst = reset;
      prev_req = {p1_req, p0_req};
      prev_we = {p1_we, p0_we};
      prev_addr[0] = p0_addr;
      prev_addr[1] = p1_addr;
      prev_data[0] = p0_wdata;
      prev_data[1] = p1_wdata;
   end

   task automatic push_cmd(input logic port, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data);
      if (port) cmdq1.push_back('{1'b0, we, addr, data});
      else      cmdq0.push_back('{1'b0, we, addr, data});
   endtask

   // latency counts edges from the one after req rose to the one raising rvalid
   task automatic wait_rvalid(input logic port, output logic [DATA_W-1:0] d, output int lat, output logic ok);
      ok = 1'b0; d = '0; lat = -1;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(posedge clk); #2;
         if (port ? p1_rvalid : p0_rvalid) begin
            d   = port ? p1_rdata : p0_rdata;
            lat = pcnt - (port ? req_cnt1 : req_cnt0);
            ok  = 1'b1;
         end
      end
      check("rvalid_seen", 64'(ok), 64'd1);
   endtask

   task automatic wait_idle(input int budget);
      logic idle;
      idle = 1'b0;
      for (int k = 0; k < budget && !idle; k++) begin
         @(posedge clk); #2;
         idle = (cmdq0.size() == 0 && cmdq1.size() == 0 && !p0_req && !p1_req &&
                 pend.size() == 0 && !busy);
      end
      check("idle_reached", 64'(idle), 64'd1);
   endtask

   task automatic do_reset();
      @(posedge clk); #3;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin : main
      logic [DATA_W-1:0] d;
      int                lat;
      logic              ok;
      int                rd_cnt, wr_cnt, busy_cnt, rv_cnt;

      vecs[0] = '{1'b0, 1'b0, 8'h10, 32'h0,        32'hC0DE0010, 3};
      vecs[1] = '{1'b1, 1'b1, 8'h05, 32'h12345678, 32'h12345678, 3};
      vecs[2] = '{1'b0, 1'b0, 8'h05, 32'h0,        32'h12345678, 3};
      vecs[3] = '{1'b0, 1'b1, 8'h80, 32'hCAFEF00D, 32'hCAFEF00D, 3};
      vecs[4] = '{1'b1, 1'b0, 8'h80, 32'h0,        32'hCAFEF00D, 3};
      vecs[5] = '{1'b1, 1'b1, 8'hFF, 32'h0F0F0F0F, 32'h0F0F0F0F, 3};
      vecs[6] = '{1'b0, 1'b0, 8'hFF, 32'h0,        32'h0F0F0F0F, 3};
      vecs[7] = '{1'b1, 1'b0, 8'h3C, 32'h0,        32'hC0DE003C, 3};

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);

      // reset while the write to 0x10 is on the cache strobes
      @(negedge clk);
      push_cmd(1'b0, 1'b1, 8'h10, 32'hDEADBEEF);
      ok = 1'b0;
      for (int k = 0; k < 10 && !ok; k++) begin
         @(posedge clk); #2;
         ok = p0_gnt;
      end
      check("abort_gnt_seen", 64'(ok), 64'd1);
      check("abort_write_strobe", 64'(mem_write), 64'd1);
      #1 reset = 1'b1;
      #1;
      check("abort_strobes_drop", 64'({mem_read, mem_write, busy}), 64'd0);
      @(posedge clk); #1 reset = 1'b0;
      rv_cnt = 0;
      repeat (5) begin
         @(negedge clk);
         rv_cnt += int'(p0_rvalid);
      end
      check("abort_no_rvalid", 64'(rv_cnt), 64'd0);

      // isolated single accesses from the vector table
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         push_cmd(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
         wait_rvalid(vecs[i].port, d, lat, ok);
         check($sformatf("vec%0d_rdata", i), 64'(d), 64'(vecs[i].exp_rdata));
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      end
      wait_idle(20);

      // write then read of the same word with req held across the grant
      @(negedge clk);
      push_cmd(1'b0, 1'b1, 8'h00, 32'hA5A5A5A5);
      push_cmd(1'b0, 1'b0, 8'h00, 32'h0);
      wait_rvalid(1'b0, d, lat, ok);
      check("b2b_write_rdata", 64'(d), 64'hA5A5A5A5);
      check("b2b_read_gnt_with_rvalid", 64'(p0_gnt), 64'd1);
      wait_rvalid(1'b0, d, lat, ok);
      check("b2b_read_rdata", 64'(d), 64'hA5A5A5A5);
      wait_idle(20);

      // both ports reading continuously
      do_reset();
      glog_port.delete();
      glog_cyc.delete();
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         push_cmd(1'b0, 1'b0, 8'h01, 32'h0);
         push_cmd(1'b1, 1'b0, 8'h02, 32'h0);
      end
      for (int k = 0; k < 80 && glog_port.size() < 12; k++) @(posedge clk);
      check("contend_grants", 64'(glog_port.size()), 64'd12);
      for (int i = 0; i < 12 && i < glog_port.size(); i++) begin
`ifdef ARB_ROUND_ROBIN_EN
         check($sformatf("contend_port%0d", i), 64'(glog_port[i]), 64'(i % 2));
`else
         check($sformatf("contend_port%0d", i), 64'(glog_port[i]), 64'(i < 6 ? 0 : 1));
`endif
         if (i > 0) check($sformatf("contend_gap%0d", i), 64'(glog_cyc[i] - glog_cyc[i-1]), 64'd2);
      end
      wait_idle(40);

      // single read: one read strobe, two busy cycles, back to idle
      @(negedge clk);
      push_cmd(1'b0, 1'b0, 8'hFF, 32'h0);
      rd_cnt = 0; wr_cnt = 0; busy_cnt = 0;
      repeat (10) begin
         @(negedge clk);
         rd_cnt   += int'(mem_read);
         wr_cnt   += int'(mem_write);
         busy_cnt += int'(busy);
      end
      check("single_read_strobes", 64'(rd_cnt), 64'd1);
      check("single_write_strobes", 64'(wr_cnt), 64'd0);
      check("single_busy_cycles", 64'(busy_cnt), 64'd2);
      check("single_state_idle", 64'(dbg_state), 64'd0);

      // randomized traffic on a small address window
      @(negedge clk);
      for (int i = 0; i < 300; i++) begin
         cmdq0.push_back('{($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                           8'($urandom_range(0, 15)), 32'($urandom)});
         cmdq1.push_back('{($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                           8'($urandom_range(0, 15)), 32'($urandom)});
      end
      wait_idle(5000);
      check("drain_pending", 64'(pend.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
